// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC controller and actuator guard.
// Holds the FSM state encoding and the temperature width.
package hvac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10,
        ST_REST = 2'b11
    } state_e;

    localparam int TEMP_W = 5;

endpackage

// File: rtl/hold_timer.sv
// Saturating up-counter used to time how long the guard dwells in a state.
// The counter clears on clr and then holds at all-ones.
module hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hvac_actuator_guard.sv
// Minimum on/off-time guard between the AC controller and the heater/cooler enables.
// Define HVAC_GUARD_STATS_EN to add the saturating activations counter port.
//
// state | meaning
// IDLE  | both actuators off, waiting for a valid request
// HEAT  | heater enabled; held for at least MIN_ON cycles
// COOL  | cooler enabled; held for at least MIN_ON cycles
// REST  | both off for at least MIN_OFF cycles after an actuator drops
module hvac_actuator_guard
    import hvac_pkg::*;
#(
    parameter int MIN_ON  = 8,
    parameter int MIN_OFF = 8,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heat_req,
    input  logic       cool_req,
    output logic       heat_out,
    output logic       cool_out,
    output logic [1:0] state_o,
    output logic       conflict
`ifdef HVAC_GUARD_STATS_EN
    ,
    output logic [15:0] activations
`endif
);

    localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(MIN_OFF - 1);

    state_e           state_d;
    state_e           state_q;
    logic             heat_out_d;
    logic             heat_out_q;
    logic             cool_out_d;
    logic             cool_out_q;
    logic             conflict_d;
    logic             conflict_q;
    logic             vh;
    logic             vc;
    logic             timer_clr;
    logic [CNT_W-1:0] timer;

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .cnt (timer)
    );

    assign vh = heat_req & ~cool_req;
    assign vc = cool_req & ~heat_req;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (vh) begin
                    state_d = ST_HEAT;
                end else if (vc) begin
                    state_d = ST_COOL;
                end
            end
            ST_HEAT: begin
                if (!vh && timer >= ON_LIM) begin
                    state_d = ST_REST;
                end
            end
            ST_COOL: begin
                if (!vc && timer >= ON_LIM) begin
                    state_d = ST_REST;
                end
            end
            ST_REST: begin
                // Requests seen while resting are ignored; only the exit-edge value counts.
                if (timer >= OFF_LIM) begin
                    if (vh) begin
                        state_d = ST_HEAT;
                    end else if (vc) begin
                        state_d = ST_COOL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        timer_clr  = (state_d != state_q);
        heat_out_d = (state_d == ST_HEAT);
        cool_out_d = (state_d == ST_COOL);
        conflict_d = heat_req & cool_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            heat_out_q <= 1'b0;
            cool_out_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            heat_out_q <= heat_out_d;
            cool_out_q <= cool_out_d;
            conflict_q <= conflict_d;
        end
    end

    assign heat_out = heat_out_q;
    assign cool_out = cool_out_q;
    assign state_o  = state_q;
    assign conflict = conflict_q;

`ifdef HVAC_GUARD_STATS_EN
    logic [15:0] act_d;
    logic [15:0] act_q;

    always_comb begin
        act_d = act_q;
        if (timer_clr && (state_d == ST_HEAT || state_d == ST_COOL) && act_q != 16'hFFFF) begin
            act_d = act_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= '0;
        end else begin
            act_q <= act_d;
        end
    end

    assign activations = act_q;
`endif

endmodule
